// File: rtl/master_port.sv
// master_port -- initiator end of the bit-serial bus.
//
// Takes one read or write at a time from a local device, requests the bus
// from the arbiter, shifts the address (and write data) out LSB first, and
// collects serial read data returned by the addressed slave_port.
//
// Ports
//   clk, rstn            clock; asynchronous active-low reset
//   dvalid/dwen/daddr/dwdata   device request (sampled only while dready=1)
//   dready               port idle; request accepted this cycle if dvalid
//   dack                 1-cycle completion pulse
//   drdata               read data, valid with dack and held afterwards
//   derr                 1-cycle pulse with dack on read timeout abort
//   mbreq / mbgrant      arbiter handshake
//   msready / msplit     target slave ready / split indication
//   mwdata/mmode/mvalid  serial address/write data, direction, bit strobe
//   mrdata / msvalid     serial read data and its per-bit strobe
//
// Build option
//   MASTER_PORT_TIMEOUT_EN  when defined, a read that sees no msvalid for
//                           TIMEOUT consecutive cycles is aborted with
//                           dack=derr=1 and drdata=0. When undefined the
//                           read waits indefinitely and derr is tied 0.

module master_port #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned TIMEOUT    = 64
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  dvalid,
   input  logic                  dwen,
   input  logic [ADDR_WIDTH-1:0] daddr,
   input  logic [DATA_WIDTH-1:0] dwdata,
   output logic                  dready,
   output logic                  dack,
   output logic [DATA_WIDTH-1:0] drdata,
   output logic                  derr,
   output logic                  mbreq,
   input  logic                  mbgrant,
   input  logic                  msready,
   input  logic                  msplit,
   output logic                  mwdata,
   output logic                  mmode,
   output logic                  mvalid,
   input  logic                  mrdata,
   input  logic                  msvalid
);

   localparam int unsigned CNT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_ADDR,
      ST_WGAP,
      ST_WDATA,
      ST_RWAIT,
      ST_DONE
   } state_t;

   state_t                state_q,  state_d;
   logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
   logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;
   logic                  mode_q,   mode_d;
   logic [CNT_W-1:0]      bitcnt_q, bitcnt_d;
   logic                  dready_q, dready_d;
   logic                  dack_q,   dack_d;
   logic [DATA_WIDTH-1:0] drdata_q, drdata_d;
   logic                  mbreq_q,  mbreq_d;
   logic                  mwdata_q, mwdata_d;
   logic                  mmode_q,  mmode_d;
   logic                  mvalid_q, mvalid_d;

`ifdef MASTER_PORT_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
   logic [TO_W-1:0]       tcnt_q,   tcnt_d;
   logic                  derr_q,   derr_d;
`endif

   // -----------------------------------------------------------------
   // Next-state and registered-output logic
   // -----------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      mode_d   = mode_q;
      bitcnt_d = bitcnt_q;
      dack_d   = 1'b0;
      drdata_d = drdata_q;
      mbreq_d  = mbreq_q;
      mwdata_d = mwdata_q;
      mmode_d  = mmode_q;
      mvalid_d = mvalid_q;
`ifdef MASTER_PORT_TIMEOUT_EN
      tcnt_d   = tcnt_q;
      derr_d   = 1'b0;
`endif

      case (state_q)
         ST_IDLE: begin
            if (dvalid) begin
               addr_d   = daddr;
               wdata_d  = dwdata;
               mode_d   = dwen;
               rdata_d  = '0;
               mbreq_d  = 1'b1;
               state_d  = ST_REQ;
            end
         end

         ST_REQ: begin
            if (mbgrant && msready) begin
               // First address bit goes out on the same edge as the grant.
               mwdata_d = addr_q[0];
               addr_d   = addr_q >> 1;
               mmode_d  = mode_q;
               mvalid_d = 1'b1;
               bitcnt_d = '0;
               state_d  = ST_ADDR;
            end
         end

         ST_ADDR: begin
            // bitcnt_q is the index of the bit currently on mwdata.
            if (bitcnt_q == CNT_W'(ADDR_WIDTH - 1)) begin
               mvalid_d = 1'b0;
               mwdata_d = 1'b0;
               bitcnt_d = '0;
               state_d  = mode_q ? ST_WGAP : ST_RWAIT;
            end else begin
               mwdata_d = addr_q[0];
               addr_d   = addr_q >> 1;
               bitcnt_d = bitcnt_q + 1'b1;
            end
         end

         ST_WGAP: begin
            mwdata_d = wdata_q[0];
            wdata_d  = wdata_q >> 1;
            mvalid_d = 1'b1;
            bitcnt_d = '0;
            state_d  = ST_WDATA;
         end

         ST_WDATA: begin
            if (bitcnt_q == CNT_W'(DATA_WIDTH - 1)) begin
               mvalid_d = 1'b0;
               mwdata_d = 1'b0;
               bitcnt_d = '0;
               dack_d   = 1'b1;
               mbreq_d  = 1'b0;
               state_d  = ST_DONE;
            end else begin
               mwdata_d = wdata_q[0];
               wdata_d  = wdata_q >> 1;
               bitcnt_d = bitcnt_q + 1'b1;
            end
         end

         ST_RWAIT: begin
            if (msplit) begin
               mbreq_d = 1'b0;
            end
            if (msvalid) begin
               // Bits arrive LSB first; shifting in at the MSB leaves each
               // bit at its own index once the last one has arrived.
               rdata_d = {mrdata, rdata_q[DATA_WIDTH-1:1]};
`ifdef MASTER_PORT_TIMEOUT_EN
               tcnt_d  = '0;
`endif
               if (bitcnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                  bitcnt_d = '0;
                  drdata_d = rdata_d;
                  dack_d   = 1'b1;
                  mbreq_d  = 1'b0;
                  state_d  = ST_DONE;
               end else begin
                  bitcnt_d = bitcnt_q + 1'b1;
               end
            end
`ifdef MASTER_PORT_TIMEOUT_EN
            else if (tcnt_q == TO_W'(TIMEOUT - 1)) begin
               tcnt_d   = '0;
               bitcnt_d = '0;
               drdata_d = '0;
               dack_d   = 1'b1;
               derr_d   = 1'b1;
               mbreq_d  = 1'b0;
               state_d  = ST_DONE;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
`endif
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      dready_d = (state_d == ST_IDLE);
   end

   // -----------------------------------------------------------------
   // State registers
   // -----------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         mode_q   <= 1'b0;
         bitcnt_q <= '0;
         dready_q <= 1'b1;
         dack_q   <= 1'b0;
         drdata_q <= '0;
         mbreq_q  <= 1'b0;
         mwdata_q <= 1'b0;
         mmode_q  <= 1'b0;
         mvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         mode_q   <= mode_d;
         bitcnt_q <= bitcnt_d;
         dready_q <= dready_d;
         dack_q   <= dack_d;
         drdata_q <= drdata_d;
         mbreq_q  <= mbreq_d;
         mwdata_q <= mwdata_d;
         mmode_q  <= mmode_d;
         mvalid_q <= mvalid_d;
      end
   end

`ifdef MASTER_PORT_TIMEOUT_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tcnt_q <= '0;
         derr_q <= 1'b0;
      end else begin
         tcnt_q <= tcnt_d;
         derr_q <= derr_d;
      end
   end

   assign derr = derr_q;
`else
   assign derr = 1'b0;
`endif

   assign dready = dready_q;
   assign dack   = dack_q;
   assign drdata = drdata_q;
   assign mbreq  = mbreq_q;
   assign mwdata = mwdata_q;
   assign mmode  = mmode_q;
   assign mvalid = mvalid_q;

endmodule

// File: tb/tb_master_port.sv
module tb_master_port;

   localparam int AW = 12;
   localparam int DW = 8;
   localparam int TO = 64;

   logic          clk = 1'b0;
   logic          rstn;
   logic          dvalid;
   logic          dwen;
   logic [AW-1:0] daddr;
   logic [DW-1:0] dwdata;
   logic          dready;
   logic          dack;
   logic [DW-1:0] drdata;
   logic          derr;
   logic          mbreq;
   logic          mbgrant;
   logic          msready;
   logic          msplit;
   logic          mwdata;
   logic          mmode;
   logic          mvalid;
   logic          mrdata;
   logic          msvalid;

   master_port #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .TIMEOUT   (TO)
   ) dut (
      .clk    (clk),
      .rstn   (rstn),
      .dvalid (dvalid),
      .dwen   (dwen),
      .daddr  (daddr),
      .dwdata (dwdata),
      .dready (dready),
      .dack   (dack),
      .drdata (drdata),
      .derr   (derr),
      .mbreq  (mbreq),
      .mbgrant(mbgrant),
      .msready(msready),
      .msplit (msplit),
      .mwdata (mwdata),
      .mmode  (mmode),
      .mvalid (mvalid),
      .mrdata (mrdata),
      .msvalid(msvalid)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [DW-1:0] rdata;
      logic          err;
   } resp_t;

   logic [1:0] exp_bits[$];   // {mmode, mwdata} per serial bit
   resp_t      exp_resp[$];

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endfunction

   function automatic void fail_event(string name, string what);
      n_vec++;
      n_err++;
      $display("FAIL %s: got %s required none", name, what);
   endfunction

   // ---------------- monitor: serial bits and completions ----------------
   always @(negedge clk) begin
      if (rstn === 1'b1) begin
         if (mvalid) begin
            if (exp_bits.size() == 0) fail_event("serial_extra", "unexpected mvalid");
            else begin
               logic [1:0] b;
               b = exp_bits.pop_front();
               check("serial_mmode", mmode, b[1]);
               check("serial_bit", mwdata, b[0]);
            end
         end
         if (dack) begin
            if (exp_resp.size() == 0) fail_event("dack_extra", "unexpected dack");
            else begin
               resp_t r;
               r = exp_resp.pop_front();
               check("resp_drdata", drdata, r.rdata);
               check("resp_derr", derr, r.err);
            end
         end
         if (derr && !dack) fail_event("derr_alone", "derr without dack");
      end
   end

   // ---------------- slave model: answers read addresses ----------------
   bit            slave_en   = 1'b1;
   int            split_cyc  = 0;
   logic [DW-1:0] slave_data = 8'hA7;
   logic          prev_mvalid = 1'b0;

   initial begin
      msvalid = 1'b0;
      mrdata  = 1'b0;
      msplit  = 1'b0;
      forever begin
         @(negedge clk);
         if (rstn === 1'b1 && prev_mvalid && !mvalid && !mmode && slave_en) begin
            // first RWAIT cycle
            if (split_cyc > 0) begin
               check("mbreq_before_split", mbreq, 1);
               msplit = 1'b1;
               repeat (split_cyc) @(negedge clk);
               msplit = 1'b0;
               check("mbreq_during_split", mbreq, 0);
            end
            for (int i = 0; i < DW; i++) begin
               @(negedge clk);
               msvalid = 1'b1;
               mrdata  = slave_data[i];
               @(negedge clk);
               msvalid = 1'b0;
               mrdata  = 1'b0;
            end
         end
         prev_mvalid = mvalid;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push_txn(input bit wen, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           input logic [DW-1:0] er, input bit ee);
      resp_t r;
      for (int i = 0; i < AW; i++) exp_bits.push_back({wen, a[i]});
      if (wen) for (int i = 0; i < DW; i++) exp_bits.push_back({1'b1, wd[i]});
      r.rdata = er;
      r.err   = ee;
      exp_resp.push_back(r);
   endtask

   task automatic request(input bit wen, input logic [AW-1:0] a, input logic [DW-1:0] wd);
      bit ok;
      ok = 1'b0;
      @(posedge clk); #1;
      dvalid = 1'b1; dwen = wen; daddr = a; dwdata = wd;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (dready) begin ok = 1'b1; break; end
      end
      if (!ok) fail_event("accept_timeout", "dready never high");
      @(posedge clk); #1;
      dvalid = 1'b0;
   endtask

   task automatic wait_dack(output int cyc);
      cyc = 0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         cyc++;
         if (dack) return;
      end
      fail_event("dack_timeout", "no dack in 500 cycles");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got simulation still running required finished");
      $fatal(1, "watchdog");
   end

   // ---------------- directed tests ----------------
   initial begin
      int cyc;
      bit exp_mv;

      rstn = 1'b0; dvalid = 1'b0; dwen = 1'b0; daddr = '0; dwdata = '0;
      mbgrant = 1'b1; msready = 1'b1;
      #12;
      check("rst_dready", dready, 1);
      check("rst_dack",   dack,   0);
      check("rst_derr",   derr,   0);
      check("rst_mbreq",  mbreq,  0);
      check("rst_mvalid", mvalid, 0);
      check("rst_mmode",  mmode,  0);
      check("rst_mwdata", mwdata, 0);
      check("rst_drdata", drdata, 0);
      @(posedge clk); #1 rstn = 1'b1;

      // 1: write 0x5A5 / 0x3C, immediate grant; cycle-exact waveform
      push_txn(1'b1, 12'h5A5, 8'h3C, 8'h00, 1'b0);
      request(1'b1, 12'h5A5, 8'h3C);
      for (int c = 1; c <= 23; c++) begin
         @(negedge clk);
         exp_mv = ((c >= 2 && c <= 13) || (c >= 15 && c <= 22));
         check("t1_mvalid", mvalid, exp_mv);
         check("t1_dack", dack, (c == 23));
      end
      @(negedge clk);
      check("t1_dready_after", dready, 1);
      check("t1_mbreq_after", mbreq, 0);

      // 2: read 0x010 with 3-cycle grant wait, slave returns 0xA7
      mbgrant = 1'b0;
      push_txn(1'b0, 12'h010, 8'h00, 8'hA7, 1'b0);
      request(1'b0, 12'h010, 8'h00);
      repeat (3) begin
         @(negedge clk);
         check("t2_wait_mbreq", mbreq, 1);
         check("t2_wait_mvalid", mvalid, 0);
      end
      mbgrant = 1'b1;
      wait_dack(cyc);
      @(negedge clk);
      check("t2_drdata_held", drdata, 8'hA7);
      check("t2_dack_pulse", dack, 0);

      // 3: read with split for 4 cycles before data
      split_cyc = 4;
      slave_data = 8'h5C;
      push_txn(1'b0, 12'h123, 8'h00, 8'h5C, 1'b0);
      request(1'b0, 12'h123, 8'h00);
      wait_dack(cyc);
      split_cyc = 0;
      slave_data = 8'hA7;

      // 4: back-to-back write then read with dvalid held high
      push_txn(1'b1, 12'h0F0, 8'h81, 8'h5C, 1'b0);  // write leaves drdata unchanged
      push_txn(1'b0, 12'h7FF, 8'h00, 8'hA7, 1'b0);
      request(1'b1, 12'h0F0, 8'h81);
      dvalid = 1'b1; dwen = 1'b0; daddr = 12'h7FF; dwdata = 8'hEE;
      begin
         bit seen;
         seen = 1'b0;
         for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("t4_dready_busy", dready, 0);
            if (dack) begin seen = 1'b1; break; end
         end
         if (!seen) fail_event("t4_first_dack", "no dack");
      end
      @(negedge clk);
      check("t4_dready_idle", dready, 1);
      @(posedge clk); #1 dvalid = 1'b0;
      wait_dack(cyc);

      // 5: read with silent slave
      slave_en = 1'b0;
`ifdef MASTER_PORT_TIMEOUT_EN
      push_txn(1'b0, 12'h222, 8'h00, 8'h00, 1'b1);
      request(1'b0, 12'h222, 8'h00);
      wait_dack(cyc);
      check("t5_timeout_latency", cyc, 1 + AW + TO + 1);
`else
      for (int i = 0; i < AW; i++) exp_bits.push_back({1'b0, 1'b0});
      exp_bits[1] = 2'b01;  // 0x222: bits 1,5,9 set
      exp_bits[5] = 2'b01;
      exp_bits[9] = 2'b01;
      request(1'b0, 12'h222, 8'h00);
      repeat (150) @(negedge clk);
      check("t5_still_busy", dready, 0);
      check("t5_still_mbreq", mbreq, 1);
      #2 rstn = 1'b0;
      @(posedge clk); #1 rstn = 1'b1;
`endif
      slave_en = 1'b1;

      // 6: reset during the 5th address bit of a write to 0xFFF
      for (int i = 0; i < AW; i++) exp_bits.push_back(2'b11);
      request(1'b1, 12'hFFF, 8'hFF);
      begin
         bit seen;
         seen = 1'b0;
         for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mvalid) begin seen = 1'b1; break; end
         end
         if (!seen) fail_event("t6_start", "no mvalid");
      end
      repeat (4) @(negedge clk);
      check("t6_pre_mwdata", mwdata, 1);
      #2 rstn = 1'b0;
      exp_bits.delete();
      exp_resp.delete();
      #1;
      check("t6_rst_dready", dready, 1);
      check("t6_rst_mvalid", mvalid, 0);
      check("t6_rst_mwdata", mwdata, 0);
      check("t6_rst_mmode",  mmode,  0);
      check("t6_rst_mbreq",  mbreq,  0);
      check("t6_rst_dack",   dack,   0);
      check("t6_rst_drdata", drdata, 0);
      @(posedge clk); #1 rstn = 1'b1;
      push_txn(1'b1, 12'h5A5, 8'h3C, 8'h00, 1'b0);
      request(1'b1, 12'h5A5, 8'h3C);
      wait_dack(cyc);
      check("t6_after_latency", cyc, 1 + AW + 1 + DW + 1);

      repeat (3) @(negedge clk);
      check("end_bits_drained", exp_bits.size(), 0);
      check("end_resp_drained", exp_resp.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
